// File: rtl/apb_arb_master.sv
// Two-requester APB master with round-robin arbitration and a PREADY wait timeout.
// Every APB and response output comes straight from a flop.
module apb_arb_master #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic                PCLK,
  input  logic                PRESET,
  input  logic [1:0]          req_valid,
  input  logic [2*ADDR_W-1:0] req_addr,
  input  logic [1:0]          req_write,
  input  logic [2*DATA_W-1:0] req_wdata,
  output logic [1:0]          req_ready,
  output logic [1:0]          rsp_valid,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err,
  output logic [ADDR_W-1:0]   PADDR,
  output logic [DATA_W-1:0]   PWDATA,
  output logic                PWRITE,
  output logic                PSEL,
  output logic                PENABLE,
  input  logic [DATA_W-1:0]   PRDATA,
  input  logic                PREADY
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  // Abort fires on the ACCESS cycle whose count would reach TIMEOUT.
  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  state_t            state_q, state_d;
  logic              grant_q, grant_d;
  logic              last_grant_q, last_grant_d;
  logic [7:0]        wait_cnt_q, wait_cnt_d;
  logic [ADDR_W-1:0] paddr_q, paddr_d;
  logic [DATA_W-1:0] pwdata_q, pwdata_d;
  logic              pwrite_q, pwrite_d;
  logic              psel_q, psel_d;
  logic              penable_q, penable_d;
  logic [1:0]        req_ready_q, req_ready_d;
  logic [1:0]        rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;
  logic              pick;

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    wait_cnt_d   = wait_cnt_q;
    paddr_d      = paddr_q;
    pwdata_d     = pwdata_q;
    pwrite_d     = pwrite_q;
    psel_d       = psel_q;
    penable_d    = penable_q;
    req_ready_d  = 2'b00;
    rsp_valid_d  = 2'b00;
    rsp_rdata_d  = '0;
    rsp_err_d    = 1'b0;

    // On a tie the requester that did not finish last wins.
    if (req_valid == 2'b11) pick = ~last_grant_q;
    else                    pick = req_valid[1];

    case (state_q)
      IDLE: begin
        if (|req_valid) begin
          state_d     = SETUP;
          grant_d     = pick;
          wait_cnt_d  = '0;
          psel_d      = 1'b1;
          penable_d   = 1'b0;
          req_ready_d = pick ? 2'b10 : 2'b01;
          paddr_d     = pick ? req_addr[ADDR_W +: ADDR_W]  : req_addr[0 +: ADDR_W];
          pwdata_d    = pick ? req_wdata[DATA_W +: DATA_W] : req_wdata[0 +: DATA_W];
          pwrite_d    = pick ? req_write[1] : req_write[0];
        end
      end
      SETUP: begin
        state_d   = ACCESS;
        penable_d = 1'b1;
      end
      ACCESS: begin
        if (PREADY || (wait_cnt_q == WAIT_LAST)) begin
          state_d      = IDLE;
          psel_d       = 1'b0;
          penable_d    = 1'b0;
          last_grant_d = grant_q;
          rsp_valid_d  = grant_q ? 2'b10 : 2'b01;
          rsp_err_d    = ~PREADY;
          rsp_rdata_d  = (PREADY && !pwrite_q) ? PRDATA : '0;
        end else begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_q      <= IDLE;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      wait_cnt_q   <= '0;
      paddr_q      <= '0;
      pwdata_q     <= '0;
      pwrite_q     <= 1'b0;
      psel_q       <= 1'b0;
      penable_q    <= 1'b0;
      req_ready_q  <= 2'b00;
      rsp_valid_q  <= 2'b00;
      rsp_rdata_q  <= '0;
      rsp_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      wait_cnt_q   <= wait_cnt_d;
      paddr_q      <= paddr_d;
      pwdata_q     <= pwdata_d;
      pwrite_q     <= pwrite_d;
      psel_q       <= psel_d;
      penable_q    <= penable_d;
      req_ready_q  <= req_ready_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_rdata_q  <= rsp_rdata_d;
      rsp_err_q    <= rsp_err_d;
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign PADDR     = paddr_q;
  assign PWDATA    = pwdata_q;
  assign PWRITE    = pwrite_q;
  assign PSEL      = psel_q;
  assign PENABLE   = penable_q;

endmodule

// File: tb/tb_apb_arb_master.sv
// Directed bench for apb_arb_master: a per-cycle vector table plus hand-written
// sequences for reset during ACCESS and round-robin tie-breaking.
module tb_apb_arb_master;

  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int TMO = 4;

  logic          PCLK = 1'b0;
  logic          PRESET;
  logic [1:0]    req_valid;
  logic [2*AW-1:0] req_addr;
  logic [1:0]    req_write;
  logic [2*DW-1:0] req_wdata;
  logic [1:0]    req_ready;
  logic [1:0]    rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic [AW-1:0] PADDR;
  logic [DW-1:0] PWDATA;
  logic          PWRITE;
  logic          PSEL;
  logic          PENABLE;
  logic [DW-1:0] PRDATA;
  logic          PREADY;

  int checks = 0;
  int fails  = 0;

  typedef struct {
    logic [1:0]  rv;
    logic [1:0]  rw;
    logic [31:0] a0;
    logic [31:0] a1;
    logic [31:0] d0;
    logic [31:0] d1;
    logic        prdy;
    logic [31:0] prdata;
    logic        psel;
    logic        pen;
    logic [31:0] paddr;
    logic        pwrite;
    logic [31:0] pwdata;
    logic [1:0]  rdy;
    logic [1:0]  rsv;
    logic [31:0] rdata;
    logic        err;
  } vec_t;

  localparam int NV = 17;
  vec_t vecs [NV];

  apb_arb_master #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TMO)) dut (
    .PCLK      (PCLK),
    .PRESET    (PRESET),
    .req_valid (req_valid),
    .req_addr  (req_addr),
    .req_write (req_write),
    .req_wdata (req_wdata),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .PADDR     (PADDR),
    .PWDATA    (PWDATA),
    .PWRITE    (PWRITE),
    .PSEL      (PSEL),
    .PENABLE   (PENABLE),
    .PRDATA    (PRDATA),
    .PREADY    (PREADY)
  );

  // Free-running 10 ns clock.
  always #5 PCLK = ~PCLK;

  function automatic vec_t mk(
    input logic [1:0] rv, input logic [1:0] rw,
    input logic [31:0] a0, input logic [31:0] a1,
    input logic [31:0] d0, input logic [31:0] d1,
    input logic prdy, input logic [31:0] prdata,
    input logic psel, input logic pen, input logic [31:0] paddr,
    input logic pwrite, input logic [31:0] pwdata,
    input logic [1:0] rdy, input logic [1:0] rsv,
    input logic [31:0] rdata, input logic err);
    vec_t v;
    v.rv = rv; v.rw = rw; v.a0 = a0; v.a1 = a1; v.d0 = d0; v.d1 = d1;
    v.prdy = prdy; v.prdata = prdata;
    v.psel = psel; v.pen = pen; v.paddr = paddr; v.pwrite = pwrite;
    v.pwdata = pwdata; v.rdy = rdy; v.rsv = rsv; v.rdata = rdata; v.err = err;
    return v;
  endfunction

  task automatic applyStimulus(input vec_t v);
    req_valid = v.rv;
    req_write = v.rw;
    req_addr  = {v.a1, v.a0};
    req_wdata = {v.d1, v.d0};
    PREADY    = v.prdy;
    PRDATA    = v.prdata;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic checkVec(input int i, input vec_t v);
    checkOutput($sformatf("v%0d PSEL", i),      32'(PSEL),      32'(v.psel));
    checkOutput($sformatf("v%0d PENABLE", i),   32'(PENABLE),   32'(v.pen));
    checkOutput($sformatf("v%0d PADDR", i),     PADDR,          v.paddr);
    checkOutput($sformatf("v%0d PWRITE", i),    32'(PWRITE),    32'(v.pwrite));
    checkOutput($sformatf("v%0d PWDATA", i),    PWDATA,         v.pwdata);
    checkOutput($sformatf("v%0d req_ready", i), 32'(req_ready), 32'(v.rdy));
    checkOutput($sformatf("v%0d rsp_valid", i), 32'(rsp_valid), 32'(v.rsv));
    checkOutput($sformatf("v%0d rsp_rdata", i), rsp_rdata,      v.rdata);
    checkOutput($sformatf("v%0d rsp_err", i),   32'(rsp_err),   32'(v.err));
  endtask

  // Main sequence: reset, vector table, reset during ACCESS, then tie arbitration.
  initial begin
    // Vector i: inputs seen at edge i, expected outputs just after edge i.
    vecs[0]  = mk(2'b01, 2'b01, 32'h10, 32'h0, 32'hA5A5A5A5, 32'h0, 1'b1, 32'h0,
                  1'b1, 1'b0, 32'h10, 1'b1, 32'hA5A5A5A5, 2'b01, 2'b00, 32'h0, 1'b0);
    vecs[1]  = mk(2'b00, 2'b01, 32'h10, 32'h0, 32'hA5A5A5A5, 32'h0, 1'b1, 32'h0,
                  1'b1, 1'b1, 32'h10, 1'b1, 32'hA5A5A5A5, 2'b00, 2'b00, 32'h0, 1'b0);
    vecs[2]  = mk(2'b00, 2'b01, 32'h10, 32'h0, 32'hA5A5A5A5, 32'h0, 1'b1, 32'h12345678,
                  1'b0, 1'b0, 32'h10, 1'b1, 32'hA5A5A5A5, 2'b00, 2'b01, 32'h0, 1'b0);
    vecs[3]  = mk(2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0,
                  1'b0, 1'b0, 32'h10, 1'b1, 32'hA5A5A5A5, 2'b00, 2'b00, 32'h0, 1'b0);
    vecs[4]  = mk(2'b10, 2'b00, 32'h0, 32'h20, 32'h0, 32'h0, 1'b0, 32'h0,
                  1'b1, 1'b0, 32'h20, 1'b0, 32'h0, 2'b10, 2'b00, 32'h0, 1'b0);
    vecs[5]  = mk(2'b00, 2'b00, 32'h0, 32'h20, 32'h0, 32'h0, 1'b0, 32'h0,
                  1'b1, 1'b1, 32'h20, 1'b0, 32'h0, 2'b00, 2'b00, 32'h0, 1'b0);
    vecs[6]  = mk(2'b01, 2'b00, 32'h99, 32'h20, 32'h55, 32'h0, 1'b0, 32'h0,
                  1'b1, 1'b1, 32'h20, 1'b0, 32'h0, 2'b00, 2'b00, 32'h0, 1'b0);
    vecs[7]  = vecs[6];
    vecs[8]  = vecs[6];
    vecs[9]  = mk(2'b01, 2'b00, 32'h99, 32'h20, 32'h55, 32'h0, 1'b1, 32'hDEADBEEF,
                  1'b0, 1'b0, 32'h20, 1'b0, 32'h0, 2'b00, 2'b10, 32'hDEADBEEF, 1'b0);
    vecs[10] = mk(2'b01, 2'b00, 32'h99, 32'h20, 32'h55, 32'h0, 1'b0, 32'h0,
                  1'b1, 1'b0, 32'h99, 1'b0, 32'h55, 2'b01, 2'b00, 32'h0, 1'b0);
    vecs[11] = mk(2'b00, 2'b00, 32'h99, 32'h20, 32'h55, 32'h0, 1'b0, 32'h0,
                  1'b1, 1'b1, 32'h99, 1'b0, 32'h55, 2'b00, 2'b00, 32'h0, 1'b0);
    vecs[12] = mk(2'b00, 2'b00, 32'h99, 32'h20, 32'h55, 32'h0, 1'b0, 32'hCAFEF00D,
                  1'b1, 1'b1, 32'h99, 1'b0, 32'h55, 2'b00, 2'b00, 32'h0, 1'b0);
    vecs[13] = vecs[12];
    vecs[14] = vecs[12];
    vecs[15] = mk(2'b00, 2'b00, 32'h99, 32'h20, 32'h55, 32'h0, 1'b0, 32'hCAFEF00D,
                  1'b0, 1'b0, 32'h99, 1'b0, 32'h55, 2'b00, 2'b01, 32'h0, 1'b1);
    vecs[16] = mk(2'b00, 2'b00, 32'h99, 32'h20, 32'h55, 32'h0, 1'b0, 32'hCAFEF00D,
                  1'b0, 1'b0, 32'h99, 1'b0, 32'h55, 2'b00, 2'b00, 32'h0, 1'b0);

    PRESET = 1'b1;
    req_valid = 2'b00; req_write = 2'b00; req_addr = '0; req_wdata = '0;
    PREADY = 1'b0; PRDATA = '0;
    #2;
    checkOutput("reset PSEL",      32'(PSEL),      32'h0);
    checkOutput("reset PENABLE",   32'(PENABLE),   32'h0);
    checkOutput("reset PADDR",     PADDR,          32'h0);
    checkOutput("reset req_ready", 32'(req_ready), 32'h0);
    checkOutput("reset rsp_valid", 32'(rsp_valid), 32'h0);
    @(posedge PCLK);
    @(negedge PCLK);
    PRESET = 1'b0;

    for (int i = 0; i < NV; i++) begin
      applyStimulus(vecs[i]);
      @(posedge PCLK);
      #1;
      checkVec(i, vecs[i]);
    end

    // Reset pulse in ACCESS: bus drops at once, no response follows.
    req_valid = 2'b10; req_write = 2'b00; req_addr = {32'h30, 32'h0}; PREADY = 1'b0;
    @(posedge PCLK); #1;
    checkOutput("rst-mid SETUP req_ready", 32'(req_ready), 32'h2);
    req_valid = 2'b00;
    @(posedge PCLK); #1;
    checkOutput("rst-mid ACCESS PENABLE", 32'(PENABLE), 32'h1);
    #2;
    PRESET = 1'b1;
    #1;
    checkOutput("rst-mid async PSEL",    32'(PSEL),    32'h0);
    checkOutput("rst-mid async PENABLE", 32'(PENABLE), 32'h0);
    @(negedge PCLK);
    PRESET = 1'b0;
    PREADY = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge PCLK); #1;
      checkOutput($sformatf("rst-mid no rsp c%0d", c), 32'(rsp_valid), 32'h0);
      checkOutput($sformatf("rst-mid idle PSEL c%0d", c), 32'(PSEL), 32'h0);
    end

    // Both requesters held valid after reset: grants alternate starting with 0.
    req_valid = 2'b11; req_write = 2'b11;
    req_addr  = {32'h44, 32'h40};
    req_wdata = {32'h1111, 32'h2222};
    PREADY = 1'b1;
    for (int t = 0; t < 4; t++) begin
      logic [1:0] exp_oh;
      exp_oh = (t % 2 == 0) ? 2'b01 : 2'b10;
      @(posedge PCLK); #1;
      checkOutput($sformatf("tie t%0d req_ready", t), 32'(req_ready), 32'(exp_oh));
      checkOutput($sformatf("tie t%0d PADDR", t), PADDR, (t % 2 == 0) ? 32'h40 : 32'h44);
      @(posedge PCLK); #1;
      checkOutput($sformatf("tie t%0d PENABLE", t), 32'(PENABLE), 32'h1);
      @(posedge PCLK); #1;
      checkOutput($sformatf("tie t%0d rsp_valid", t), 32'(rsp_valid), 32'(exp_oh));
      checkOutput($sformatf("tie t%0d rsp_err", t), 32'(rsp_err), 32'h0);
    end
    req_valid = 2'b00;

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
